// File: rtl/insn_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The byte source drives the master side; the loader sits on the slave side,
// accepting bytes and producing memory writes.
interface insn_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/insn_loader.sv
// Program loader: parses a framed byte stream (sync, 16-bit word count,
// little-endian words, 8-bit additive checksum), writes each word to
// consecutive instruction-memory addresses from 0 and holds the core in
// reset until the whole image has arrived with a matching checksum.
module insn_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    insn_loader_if.slave bus,
    output logic         core_reset,
    output logic         done,
    output logic         error
);

    // Largest legal word count; the counter is 17 bits so 2^16 fits too.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                r_state;
    logic [7:0]            r_len_lo;
    logic [16:0]           r_remain;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_lane;
    logic [7:0]            r_sum;
    logic [23:0]           r_word;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic                  r_done;
    logic                  r_error;
    logic                  r_core_rst_n;

    logic                  w_ready;
    logic                  w_take;
    logic                  w_sync;
    logic [16:0]           w_len;

    // Running checksum: plain 8-bit add, wrapping modulo 256.
    function automatic logic [7:0] f_sum_add(input logic [7:0] sum,
                                             input logic [7:0] b);
        return sum + b;
    endfunction

    // Place a byte into one of the three lower lanes of the partial word.
    function automatic logic [23:0] f_lane_insert(input logic [23:0] word,
                                                  input logic [1:0]  lane,
                                                  input logic [7:0]  b);
        logic [23:0] res;
        res = word;
        case (lane)
            2'd0:    res = {word[23:8], b};
            2'd1:    res = {word[23:16], b, word[7:0]};
            2'd2:    res = {b, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // No back-pressure: the loader keeps up with one byte per cycle.
    assign w_ready = 1'b1;
    assign w_take  = bus.in_valid & w_ready;
    assign w_sync  = (bus.in_data == SYNC_BYTE);
    assign w_len   = {1'b0, bus.in_data, r_len_lo};

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_waddr;
    assign bus.mem_wdata = r_wdata;
    assign core_reset    = r_core_rst_n;
    assign done          = r_done;
    assign error         = r_error;

    // Frame parser FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= 8'd0;
            r_remain     <= 17'd0;
            r_addr       <= '0;
            r_lane       <= 2'd0;
            r_sum        <= 8'd0;
            r_word       <= 24'd0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= 32'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data hold.
            r_we <= 1'b0;
            if (w_take) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_sync) begin
                            r_state <= ST_LEN_LO;
                            r_sum   <= 8'd0;
                        end
                    end
                    ST_LEN_LO: begin
                        r_len_lo <= bus.in_data;
                        r_state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        if (w_len > MAX_WORDS) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else if (w_len == 17'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state  <= ST_DATA;
                            r_remain <= w_len;
                            r_addr   <= '0;
                            r_lane   <= 2'd0;
                        end
                    end
                    ST_DATA: begin
                        r_sum  <= f_sum_add(r_sum, bus.in_data);
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_we     <= 1'b1;
                            r_waddr  <= r_addr;
                            r_wdata  <= {bus.in_data, r_word};
                            // Wraps to 0 after a full-size image; harmless
                            // because the FSM leaves DATA on the same byte.
                            r_addr   <= r_addr + 1'b1;
                            r_remain <= r_remain - 17'd1;
                            if (r_remain == 17'd1) begin
                                r_state <= ST_CSUM;
                            end
                        end else begin
                            r_word <= f_lane_insert(r_word, r_lane, bus.in_data);
                        end
                    end
                    ST_CSUM: begin
                        if (bus.in_data == r_sum) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        // A new sync byte starts a reload and re-holds the core.
                        if (w_sync) begin
                            r_state      <= ST_LEN_LO;
                            r_done       <= 1'b0;
                            r_error      <= 1'b0;
                            r_core_rst_n <= 1'b0;
                            r_sum        <= 8'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: directed frames plus randomized
// frames with gaps, compared against a frame-level reference model.
module tb_insn_loader;

    localparam int AW = 10;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic core_reset;
    logic done;
    logic error;

    insn_loader_if #(.ADDR_WIDTH(AW)) bus ();

    insn_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    bit            exp_done;
    bit            exp_err;
    bq_t           frame;
    bq_t           good_img;

    // Every cycle with the strobe high is recorded as a separate write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            cap_addr.push_back(bus.mem_addr);
            cap_data.push_back(bus.mem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        clear_caps();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t q, input int gap_max);
        foreach (q[i]) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    bus.in_data = 8'($urandom);
                    tick();
                end
            end
            send_byte(q[i]);
        end
    endtask

    // Frame of n random words; checksum optionally corrupted.
    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] b;
        int sum;
        sum = 0;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            frame.push_back(b);
            sum += int'(b);
        end
        frame.push_back(8'(sum) ^ (corrupt ? 8'($urandom_range(255, 1)) : 8'h00));
    endtask

    // Reference: find sync, read the count, gather words, compare the sum.
    task automatic model_frame(input bq_t q);
        int i;
        int n;
        int sum;
        int base;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 >= q.size()) return;
        n = int'(q[i+1]) + 256 * int'(q[i+2]);
        base = i + 3;
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(AW'(w));
            exp_data.push_back({q[base+4*w+3], q[base+4*w+2], q[base+4*w+1], q[base+4*w]});
            for (int k = 0; k < 4; k++) sum += int'(q[base+4*w+k]);
        end
        if (base + 4 * n < q.size()) begin
            exp_done = (q[base+4*n] == 8'(sum % 256));
            exp_err  = !exp_done;
        end
    endtask

    function automatic bit writes_match();
        if (cap_addr.size() != exp_addr.size()) return 1'b0;
        foreach (exp_addr[i]) begin
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_reset, done, error}
            !== {1'b1, 1'b0, {AW{1'b0}}, 32'd0, 1'b0, 1'b0, 1'b0})
            begin errors++; $display("FAIL reset_outputs: rdy=%b we=%b addr=%0h wdata=%h core=%b done=%b err=%b, required 1 0 0 0 0 0 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_reset, done, error); end
    endtask

    task automatic test_good_image();
        do_reset();
        send_stream('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(0) || bus.mem_wdata !== 32'h12345678)
            begin errors++; $display("FAIL good_write0: we=%b addr=%0h data=%h, required 1 0 12345678", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        send_byte(8'hEF);
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== AW'(0))
            begin errors++; $display("FAIL good_we_pulse: we=%b addr=%0h, required 0 0", bus.mem_we, bus.mem_addr); end
        send_stream('{8'hBE, 8'hAD, 8'hDE}, 0);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(1) || bus.mem_wdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL good_write1: we=%b addr=%0h data=%h, required 1 1 deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL good_hold_before_csum: core=%b done=%b, required 0 0", core_reset, done); end
        // Modulo-256 sum of the eight data bytes is 0x4C.
        send_byte(8'h4C);
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b1 || error !== 1'b0)
            begin errors++; $display("FAIL good_done: done=%b core=%b err=%b, required 1 1 0", done, core_reset, error); end
        model_frame(good_img);
        checks++;
        if (!writes_match())
            begin errors++; $display("FAIL good_writes: got %0d writes, required %0d", cap_addr.size(), exp_addr.size()); end
    endtask

    task automatic test_bad_csum();
        bq_t q;
        do_reset();
        q = good_img;
        q[q.size()-1] = 8'h8E;
        send_stream(q, 0);
        model_frame(q);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b0)
            begin errors++; $display("FAIL bad_csum_flags: err=%b done=%b core=%b, required 1 0 0", error, done, core_reset); end
        checks++;
        if (!writes_match() || cap_addr.size() != 2)
            begin errors++; $display("FAIL bad_csum_writes: got %0d writes, required 2", cap_addr.size()); end
    endtask

    task automatic test_junk_gaps();
        bq_t q;
        do_reset();
        q = '{8'h00, 8'hFF, 8'h5A};
        foreach (good_img[i]) q.push_back(good_img[i]);
        send_stream(q, 3);
        repeat (3) tick();
        model_frame(q);
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b1 || error !== 1'b0)
            begin errors++; $display("FAIL junk_flags: done=%b core=%b err=%b, required 1 1 0", done, core_reset, error); end
        checks++;
        if (!writes_match())
            begin errors++; $display("FAIL junk_writes: got %0d writes, required %0d", cap_addr.size(), exp_addr.size()); end
    endtask

    task automatic test_lengths();
        do_reset();
        send_stream('{8'hA5, 8'h01, 8'h04}, 0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b0)
            begin errors++; $display("FAIL oversize_flags: err=%b done=%b core=%b, required 1 0 0", error, done, core_reset); end
        send_stream('{8'h00, 8'h11, 8'h22, 8'h33}, 0);
        checks++;
        if (cap_addr.size() != 0 || error !== 1'b1)
            begin errors++; $display("FAIL oversize_writes: got %0d writes err=%b, required 0 writes err=1", cap_addr.size(), error); end
        do_reset();
        send_stream('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b1 || error !== 1'b0 || cap_addr.size() != 0)
            begin errors++; $display("FAIL zero_len: done=%b core=%b err=%b writes=%0d, required 1 1 0 0", done, core_reset, error, cap_addr.size()); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        send_stream(good_img, 0);
        clear_caps();
        send_stream('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56}, 0);
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, core_reset, done, error}
            !== {1'b0, {AW{1'b0}}, 32'd0, 1'b0, 1'b0, 1'b0})
            begin errors++; $display("FAIL midreset_outputs: we=%b addr=%0h wdata=%h core=%b done=%b err=%b, required all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, core_reset, done, error); end
        reset = 1'b0;
        tick();
        checks++;
        if (cap_addr.size() != 0)
            begin errors++; $display("FAIL midreset_nowrite: got %0d writes, required 0", cap_addr.size()); end
        send_stream(good_img, 1);
        model_frame(good_img);
        checks++;
        if (!writes_match() || done !== 1'b1 || core_reset !== 1'b1)
            begin errors++; $display("FAIL midreset_reload: writes=%0d done=%b core=%b, required %0d 1 1", cap_addr.size(), done, core_reset, exp_addr.size()); end
    endtask

    task automatic test_reload();
        bq_t rest;
        do_reset();
        send_stream(good_img, 0);
        clear_caps();
        build_frame(3, 1'b0);
        send_byte(frame[0]);
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL reload_hold: core=%b done=%b, required 0 0", core_reset, done); end
        rest = frame;
        void'(rest.pop_front());
        send_stream(rest, 0);
        model_frame(frame);
        checks++;
        if (!writes_match() || done !== 1'b1 || core_reset !== 1'b1)
            begin errors++; $display("FAIL reload_load: writes=%0d done=%b core=%b, required %0d 1 1", cap_addr.size(), done, core_reset, exp_addr.size()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 24; it++) begin
            clear_caps();
            build_frame($urandom_range(6, 0), ($urandom_range(3, 0) == 0));
            if ($urandom_range(1, 0) == 1) frame.push_front(8'($urandom_range(8'hA4, 0)));
            send_stream(frame, 2);
            repeat (2) tick();
            model_frame(frame);
            checks++;
            if (!writes_match() || done !== exp_done || error !== exp_err || core_reset !== exp_done)
                begin errors++; $display("FAIL random_frame%0d: writes=%0d done=%b err=%b core=%b, required %0d %b %b %b",
                         it, cap_addr.size(), done, error, core_reset, exp_addr.size(), exp_done, exp_err, exp_done); end
        end
    endtask

    task automatic test_full_size();
        do_reset();
        build_frame(1 << AW, 1'b0);
        send_stream(frame, 0);
        repeat (4) tick();
        model_frame(frame);
        checks++;
        if (cap_addr.size() != (1 << AW) || cap_addr[cap_addr.size()-1] !== AW'((1 << AW) - 1))
            begin errors++; $display("FAIL full_last_addr: writes=%0d, required %0d ending at %0h", cap_addr.size(), 1 << AW, (1 << AW) - 1); end
        checks++;
        if (!writes_match() || done !== 1'b1 || core_reset !== 1'b1 || bus.mem_we !== 1'b0)
            begin errors++; $display("FAIL full_load: match=%b done=%b core=%b we=%b, required 1 1 1 0", writes_match(), done, core_reset, bus.mem_we); end
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        good_img = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        test_reset();
        test_good_image();
        test_bad_csum();
        test_junk_gaps();
        test_lengths();
        test_reset_mid_word();
        test_reload();
        test_random();
        test_full_size();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
